// File: rtl/systolic_pkg.sv
// Shared constants and FSM state encoding for the systolic tile scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: array geometry (N, DATA_W, ADDR_W), compute window length (CMP_CYC),
// load index and compute counter widths, compute FSM state enum.
package systolic_pkg;

    localparam int N          = 16;
    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 8;              // clog2(N*N)
    localparam int CMP_CYC    = 3 * N - 2;      // swap -> C outputs final
    localparam int TILE_BEATS = N * N;          // elements per operand tile
    localparam int IDX_W      = 9;              // indexes 0 .. 2*N*N-1
    localparam int CNT_W      = 6;              // holds CMP_CYC-1

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWAP,
        S_COMPUTE,
        S_RESULT
    } state_t;

endpackage

// File: rtl/systolic_tile_sched_if.sv
// Operand stream and result handshake bundle of the tile scheduler.
// Latency: n/a (wires only).
// Backpressure: stream via s_valid/s_ready, result via res_valid/res_ready.
//
// master: tile producer + result consumer (drives s_*, res_ready).
// slave : the scheduler (drives s_ready, res_valid).
interface systolic_tile_sched_if;

    logic                           s_valid;
    logic                           s_ready;
    logic [systolic_pkg::DATA_W-1:0] s_data;
    logic                           s_last;
    logic                           res_valid;
    logic                           res_ready;

    modport master (
        output s_valid, s_data, s_last, res_ready,
        input  s_ready, res_valid
    );

    modport slave (
        input  s_valid, s_data, s_last, res_ready,
        output s_ready, res_valid
    );

endinterface

// File: rtl/systolic_tile_loader.sv
// Stream-to-SRAM write side: steers A then B beats into the shadow bank, tracks tile completion.
// Latency: SRAM write strobes are combinational from the accepted beat; shadow_full one cycle later.
// Backpressure: s_ready = ~shadow_full; stalls until the compute side swaps banks.
//
// Ports: clk, rst (sync, active-high); s_valid/s_data/s_last/s_ready stream;
// clr_full (bank swap releases the shadow bank); we/addr/din for SRAM A and B;
// shadow_full (complete tile waiting), tile_done (good last beat accepted this cycle);
// err_len (sticky framing error).
module systolic_tile_loader
    import systolic_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    input  logic              clr_full,
    output logic              we_a,
    output logic [ADDR_W-1:0] addr_a,
    output logic [DATA_W-1:0] din_a,
    output logic              we_b,
    output logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] din_b,
    output logic              shadow_full,
    output logic              tile_done,
    output logic              err_len
);

    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             final_beat;
    logic             in_b;

    assign s_ready    = ~shadow_full;
    assign accept     = s_valid & s_ready;
    assign final_beat = (idx == IDX_W'(2 * TILE_BEATS - 1));
    assign in_b       = (idx >= IDX_W'(TILE_BEATS));
    assign tile_done  = accept & final_beat & s_last;

    // A tile is exactly two power-of-two operand halves, so the low index bits
    // are the word address within either half.
    assign we_a   = accept & ~in_b;
    assign we_b   = accept & in_b;
    assign addr_a = we_a ? idx[ADDR_W-1:0] : '0;
    assign addr_b = we_b ? idx[ADDR_W-1:0] : '0;
    assign din_a  = we_a ? s_data : '0;
    assign din_b  = we_b ? s_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= '0;
            shadow_full <= 1'b0;
            err_len     <= 1'b0;
        end else begin
            if (clr_full) begin
                shadow_full <= 1'b0;
            end
            if (accept) begin
                if (final_beat || s_last) begin
                    // Either a clean tile end or a framing error: both restart
                    // at beat 0. A bad tile is dropped; the words it left in the
                    // shadow bank are simply overwritten by the next tile.
                    idx <= '0;
                    if (final_beat && s_last) begin
                        shadow_full <= 1'b1;
                    end else begin
                        err_len <= 1'b1;
                    end
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/systolic_tile_sched.sv
// Tile scheduler for the 16x16 systolic MMA array: ping-pong A/B SRAM banks, compute window timing.
// Latency: last beat at t -> bank swap at t+1 (if idle) -> res_valid at t+2+CMP_CYC.
// Backpressure: stream stalls while a loaded tile waits; result held until res_ready.
//
// Ports: clk, rst (sync, active-high); bus (slave modport: stream + result handshake);
// we/addr/din for SRAM A and B (shadow bank); select_buf (active bank); array_rst (PE clear);
// busy; err_len. Build option SYSTOLIC_TILE_SCHED_PERF_EN adds perf_tiles / perf_stall counters.
module systolic_tile_sched
    import systolic_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    systolic_tile_sched_if.slave  bus,
    output logic                  we_a,
    output logic                  we_b,
    output logic [ADDR_W-1:0]     addr_a,
    output logic [ADDR_W-1:0]     addr_b,
    output logic [DATA_W-1:0]     din_a,
    output logic [DATA_W-1:0]     din_b,
    output logic                  select_buf,
    output logic                  array_rst,
    output logic                  busy,
    output logic                  err_len
`ifdef SYSTOLIC_TILE_SCHED_PERF_EN
    ,
    output logic [31:0]           perf_tiles,
    output logic [31:0]           perf_stall
`endif
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             select_q;
    logic             array_rst_q;
    logic             busy_q;
    logic             res_valid_q;

    logic             s_ready_w;
    logic             shadow_full;
    logic             tile_done;
    logic             clr_full;
    logic             full_nxt;

    systolic_tile_loader u_loader (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (bus.s_valid),
        .s_data      (bus.s_data),
        .s_last      (bus.s_last),
        .s_ready     (s_ready_w),
        .clr_full    (clr_full),
        .we_a        (we_a),
        .addr_a      (addr_a),
        .din_a       (din_a),
        .we_b        (we_b),
        .addr_b      (addr_b),
        .din_b       (din_b),
        .shadow_full (shadow_full),
        .tile_done   (tile_done),
        .err_len     (err_len)
    );

    assign bus.s_ready   = s_ready_w;
    assign bus.res_valid = res_valid_q;
    assign select_buf    = select_q;
    assign array_rst     = array_rst_q;
    assign busy          = busy_q;

    // The shadow bank is released during the SWAP cycle itself.
    assign clr_full = (state == S_SWAP);

    // Looking at the loader's next-cycle fill state lets the swap land on the
    // cycle right after the last beat, with all FSM outputs still registered.
    // Outside SWAP nothing clears shadow_full, so this is its exact next value.
    assign full_nxt = shadow_full | tile_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            select_q    <= 1'b0;
            array_rst_q <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            array_rst_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (full_nxt) begin
                        state       <= S_SWAP;
                        select_q    <= ~select_q;
                        array_rst_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                S_SWAP: begin
                    state <= S_COMPUTE;
                    cnt   <= CNT_W'(CMP_CYC - 1);
                end
                S_COMPUTE: begin
                    if (cnt == '0) begin
                        state       <= S_RESULT;
                        res_valid_q <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_RESULT: begin
                    // Active bank and C stay frozen until the consumer takes C.
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        if (full_nxt) begin
                            state       <= S_SWAP;
                            select_q    <= ~select_q;
                            array_rst_q <= 1'b1;
                        end else begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    busy_q      <= 1'b0;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef SYSTOLIC_TILE_SCHED_PERF_EN
    // perf_stall counts cycles a finished tile sits in the shadow bank while
    // the array is occupied, including the swap cycle that releases it.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_tiles <= '0;
            perf_stall <= '0;
        end else begin
            if (res_valid_q && bus.res_ready) begin
                perf_tiles <= perf_tiles + 32'd1;
            end
            if ((state != S_IDLE) && shadow_full) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_systolic_tile_sched.sv
// Directed bench for systolic_tile_sched: load, swap timing, back-to-back, framing errors,
// random valid gaps, reset recovery, and (SYSTOLIC_TILE_SCHED_PERF_EN) perf counters.
module tb_systolic_tile_sched;
    import systolic_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic_tile_sched_if bus();

    logic       we_a, we_b;
    logic [7:0] addr_a, addr_b, din_a, din_b;
    logic       select_buf, array_rst, busy, err_len;
`ifdef SYSTOLIC_TILE_SCHED_PERF_EN
    logic [31:0] perf_tiles, perf_stall;
`endif

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    systolic_tile_sched dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .we_a       (we_a),
        .we_b       (we_b),
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .din_a      (din_a),
        .din_b      (din_b),
        .select_buf (select_buf),
        .array_rst  (array_rst),
        .busy       (busy),
        .err_len    (err_len)
`ifdef SYSTOLIC_TILE_SCHED_PERF_EN
        ,
        .perf_tiles (perf_tiles),
        .perf_stall (perf_stall)
`endif
    );

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout need finish");
        $fatal(1);
    end

    function automatic logic [7:0] beat_data(input int i, input logic [7:0] pat);
        logic [7:0] v;
        if (i < 256) v = 8'(i);
        else         v = 8'(511 - i);
        return v ^ pat;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.s_valid   = 1'b0;
        bus.s_last    = 1'b0;
        bus.s_data    = 8'h00;
        bus.res_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // Drives nbeats beats (s_last on beat last_at) and checks every SRAM write.
    // Returns at #1 after the negedge following the last accepted beat.
    task automatic load_tile(input int nbeats, input int last_at, input bit rnd,
                             input logic [7:0] pat);
        int          i;
        int          guard;
        logic        v;
        logic [7:0]  d;
        logic [33:0] exp_w;
        logic [34:0] got_w;
        i = 0;
        guard = 0;
        while (i < nbeats && guard < 4000) begin
            @(negedge clk);
            guard++;
            v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            d = beat_data(i, pat);
            bus.s_valid = v;
            bus.s_data  = d;
            bus.s_last  = (i == last_at);
            #1;
            if (!v)           exp_w = '0;
            else if (i < 256) exp_w = {1'b1, 8'(i), d, 1'b0, 8'h00, 8'h00};
            else              exp_w = {1'b0, 8'h00, 8'h00, 1'b1, 8'(i - 256), d};
            got_w = {bus.s_ready, we_a, addr_a, din_a, we_b, addr_b, din_b};
            compared++;
            if (got_w !== {1'b1, exp_w}) begin
                mismatched++;
                if (mismatched <= 30)
                    $display("FAIL load_beat %0d: got %h need %h", i, got_w, {1'b1, exp_w});
            end
            if (v) i++;
        end
        if (i < nbeats) begin
            compared++;
            mismatched++;
            $display("FAIL load_timeout: got %0d beats need %0d", i, nbeats);
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        #1;
    endtask

    // Waits for res_valid and checks it rises exactly 47 cycles after the swap cycle.
    task automatic wait_result(input int swap_cyc, input string name);
        int g;
        g = 0;
        while (bus.res_valid !== 1'b1 && g < 300) begin
            @(negedge clk);
            #1;
            g++;
        end
        compared++;
        if (bus.res_valid !== 1'b1 || (cyc - swap_cyc) != 47) begin
            mismatched++;
            $display("FAIL %s_latency: got res_valid=%b after %0d cycles need 1 after 47",
                     name, bus.res_valid, cyc - swap_cyc);
        end
    endtask

    task automatic consume();
        @(negedge clk);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        compared++;
        if ({we_a, we_b, addr_a, addr_b, din_a, din_b, select_buf, array_rst, busy,
             bus.res_valid, err_len, bus.s_ready} !== {40'h0, 1'b1}) begin
            mismatched++;
            $display("FAIL reset_state: got we=%b%b sel=%b rst=%b busy=%b rv=%b err=%b rdy=%b need all 0, rdy=1",
                     we_a, we_b, select_buf, array_rst, busy, bus.res_valid, err_len, bus.s_ready);
        end
    endtask

    task automatic test_single_tile();
        int sw;
        do_reset();
        load_tile(512, 511, 1'b0, 8'h00);
        sw = cyc;
        compared++;
        if ({select_buf, array_rst, busy, bus.s_ready, bus.res_valid, err_len} !== 6'b111000) begin
            mismatched++;
            $display("FAIL t1_swap: got sel/arst/busy/rdy/rv/err=%b need 111000",
                     {select_buf, array_rst, busy, bus.s_ready, bus.res_valid, err_len});
        end
        @(negedge clk);
        #1;
        compared++;
        if ({array_rst, bus.s_ready, busy} !== 3'b011) begin
            mismatched++;
            $display("FAIL t1_after_swap: got arst/rdy/busy=%b need 011",
                     {array_rst, bus.s_ready, busy});
        end
        wait_result(sw, "t1");
        repeat (3) @(negedge clk);
        #1;
        compared++;
        if ({bus.res_valid, select_buf} !== 2'b11) begin
            mismatched++;
            $display("FAIL t1_hold: got rv/sel=%b need 11", {bus.res_valid, select_buf});
        end
        consume();
        compared++;
        if ({bus.res_valid, busy, select_buf} !== 3'b001) begin
            mismatched++;
            $display("FAIL t1_consume: got rv/busy/sel=%b need 001",
                     {bus.res_valid, busy, select_buf});
        end
    endtask

    task automatic test_back_to_back();
        int sw2;
        do_reset();
        load_tile(512, 511, 1'b0, 8'h5A);
        compared++;
        if ({select_buf, array_rst} !== 2'b11) begin
            mismatched++;
            $display("FAIL b2b_swap1: got sel/arst=%b need 11", {select_buf, array_rst});
        end
        load_tile(512, 511, 1'b0, 8'hC3);
        for (int k = 0; k < 100; k++) begin
            compared++;
            if ({bus.s_ready, busy, bus.res_valid, select_buf, array_rst} !== 5'b01110) begin
                mismatched++;
                $display("FAIL b2b_hold cycle %0d: got rdy/busy/rv/sel/arst=%b need 01110",
                         k, {bus.s_ready, busy, bus.res_valid, select_buf, array_rst});
            end
            @(negedge clk);
            #1;
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        #1;
        sw2 = cyc;
        compared++;
        if ({select_buf, array_rst, busy, bus.res_valid, bus.s_ready} !== 5'b01100) begin
            mismatched++;
            $display("FAIL b2b_swap2: got sel/arst/busy/rv/rdy=%b need 01100",
                     {select_buf, array_rst, busy, bus.res_valid, bus.s_ready});
        end
        @(negedge clk);
        #1;
        compared++;
        if ({bus.s_ready, array_rst} !== 2'b10) begin
            mismatched++;
            $display("FAIL b2b_release: got rdy/arst=%b need 10", {bus.s_ready, array_rst});
        end
        wait_result(sw2, "b2b");
        consume();
        compared++;
        if ({busy, select_buf} !== 2'b00) begin
            mismatched++;
            $display("FAIL b2b_done: got busy/sel=%b need 00", {busy, select_buf});
        end
    endtask

    task automatic test_len_error();
        int sw;
        load_tile(301, 300, 1'b0, 8'h11);
        compared++;
        if ({err_len, busy, select_buf, array_rst, bus.s_ready} !== 5'b10001) begin
            mismatched++;
            $display("FAIL err_early_last: got err/busy/sel/arst/rdy=%b need 10001",
                     {err_len, busy, select_buf, array_rst, bus.s_ready});
        end
        repeat (5) @(negedge clk);
        #1;
        compared++;
        if ({busy, select_buf} !== 2'b00) begin
            mismatched++;
            $display("FAIL err_no_swap: got busy/sel=%b need 00", {busy, select_buf});
        end
        load_tile(512, -1, 1'b0, 8'h44);
        repeat (2) @(negedge clk);
        #1;
        compared++;
        if ({err_len, busy, select_buf, bus.s_ready} !== 4'b1001) begin
            mismatched++;
            $display("FAIL err_missing_last: got err/busy/sel/rdy=%b need 1001",
                     {err_len, busy, select_buf, bus.s_ready});
        end
        load_tile(512, 511, 1'b0, 8'h22);
        sw = cyc;
        compared++;
        if ({select_buf, array_rst, err_len} !== 3'b111) begin
            mismatched++;
            $display("FAIL err_recover_swap: got sel/arst/err=%b need 111",
                     {select_buf, array_rst, err_len});
        end
        wait_result(sw, "err_recover");
        consume();
    endtask

    task automatic test_random_valid();
        int sw;
        load_tile(512, 511, 1'b1, 8'h77);
        sw = cyc;
        compared++;
        if ({select_buf, array_rst, busy} !== 3'b011) begin
            mismatched++;
            $display("FAIL rnd_swap: got sel/arst/busy=%b need 011",
                     {select_buf, array_rst, busy});
        end
        wait_result(sw, "rnd");
        consume();
    endtask

    task automatic test_reset_recovery();
        int sw;
        do_reset();
        load_tile(200, -1, 1'b0, 8'h99);
        do_reset();
        compared++;
        if ({we_a, we_b, addr_a, addr_b, din_a, din_b, select_buf, array_rst, busy,
             bus.res_valid, err_len, bus.s_ready} !== {40'h0, 1'b1}) begin
            mismatched++;
            $display("FAIL rst_mid_load: got we=%b%b sel=%b busy=%b rv=%b rdy=%b need 0 0 0 0 0 1",
                     we_a, we_b, select_buf, busy, bus.res_valid, bus.s_ready);
        end
        load_tile(512, 511, 1'b0, 8'h3C);
        compared++;
        if ({select_buf, array_rst} !== 2'b11) begin
            mismatched++;
            $display("FAIL rst_load_swap: got sel/arst=%b need 11", {select_buf, array_rst});
        end
        repeat (20) @(negedge clk);
        #1;
        compared++;
        if ({busy, bus.res_valid} !== 2'b10) begin
            mismatched++;
            $display("FAIL rst_mid_compute_pre: got busy/rv=%b need 10", {busy, bus.res_valid});
        end
        do_reset();
        compared++;
        if ({select_buf, array_rst, busy, bus.res_valid, err_len, we_a, we_b} !== 7'b0) begin
            mismatched++;
            $display("FAIL rst_mid_compute: got sel/arst/busy/rv/err/we=%b need 0000000",
                     {select_buf, array_rst, busy, bus.res_valid, err_len, we_a, we_b});
        end
        load_tile(512, 511, 1'b0, 8'hA5);
        sw = cyc;
        compared++;
        if ({select_buf, array_rst} !== 2'b11) begin
            mismatched++;
            $display("FAIL rst_recover_swap: got sel/arst=%b need 11", {select_buf, array_rst});
        end
        wait_result(sw, "rst_recover");
        consume();
    endtask

`ifdef SYSTOLIC_TILE_SCHED_PERF_EN
    task automatic test_perf();
        int sw;
        do_reset();
        // Tile 1: one stall cycle (its swap cycle).
        load_tile(512, 511, 1'b0, 8'h01);
        // Tile 2 loads while tile 1 computes; its result is held unconsumed.
        load_tile(512, 511, 1'b0, 8'h02);
        // Tile 2 waits 21 cycles in RESULT with shadow full, then its swap: 22.
        repeat (20) @(negedge clk);
        #1;
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        #1;
        sw = cyc;
        wait_result(sw, "perf_t2");
        consume();
        // Tile 3 alone: one stall cycle.
        load_tile(512, 511, 1'b0, 8'h03);
        sw = cyc;
        wait_result(sw, "perf_t3");
        consume();
        compared++;
        if (perf_tiles !== 32'd3) begin
            mismatched++;
            $display("FAIL perf_tiles: got %0d need 3", perf_tiles);
        end
        compared++;
        if (perf_stall !== 32'd24) begin
            mismatched++;
            $display("FAIL perf_stall: got %0d need 24", perf_stall);
        end
    endtask
`endif

    initial begin
        rst           = 1'b1;
        bus.s_valid   = 1'b0;
        bus.s_last    = 1'b0;
        bus.s_data    = 8'h00;
        bus.res_ready = 1'b0;
        test_reset();
        test_single_tile();
        test_back_to_back();
        test_len_error();
        test_random_valid();
        test_reset_recovery();
`ifdef SYSTOLIC_TILE_SCHED_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
